boot_flash_emu: RTL and testbench

//  Parametrised successor of the boot-flash front end. Emulates a byte-wide parallel flash on the
//  CPU boot bus and serves a programmable instruction pattern (reset value: PowerPC NOP 0x60000000).

---
 rtl/boot_flash_emu_pkg.sv | 15 +
 rtl/cap_fifo.sv | 63 ++++++
 rtl/boot_flash_emu.sv | 141 ++++++++++++++
 tb/tb_boot_flash_emu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_flash_emu_pkg.sv
// Shared constants and elaboration-time helpers for the boot-flash emulator.
package boot_flash_emu_pkg;

  localparam logic [31:0] NOP_WORD = 32'h6000_0000;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // $clog2 that never yields a zero-width select
  function automatic int unsigned clog2_min1(input int unsigned val);
    return (val <= 1) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Capture FIFO: power-of-two ring buffer with flush, occupancy and combinational head.
module cap_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_c_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop_i & ~empty & ~clr_i;
    do_push  = push_i & (~full | do_pop) & ~clr_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: rtl/boot_flash_emu.sv
// Byte-wide parallel flash emulator: serves a programmable pattern on the boot bus and
// captures fetch addresses for sliced host readout.
module boot_flash_emu
  import boot_flash_emu_pkg::*;
#(
  parameter int unsigned ADDR_N    = 19,
  parameter int unsigned DATA_N    = 8,
  parameter int unsigned PAT_DEPTH = 8,
  parameter int unsigned CAP_DEPTH = 4,
  parameter int unsigned CHUNK_N   = 2,
  localparam int unsigned NCHUNK   = ceil_div(ADDR_N, CHUNK_N),
  localparam int unsigned IDX_W    = clog2_min1(PAT_DEPTH),
  localparam int unsigned SEL_W    = clog2_min1(NCHUNK),
  localparam int unsigned CNT_W    = $clog2(CAP_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_N-1:0] address,
  input  logic              _e,
  input  logic              _g,
  output logic [DATA_N-1:0] x_data,
  output logic              x_data_oe,
  input  logic              i_mode,
  input  logic              i_clr,
  input  logic              i_pat_we,
  input  logic [IDX_W-1:0]  i_pat_idx,
  input  logic [DATA_N-1:0] i_pat_data,
  input  logic              i_pop,
  input  logic [SEL_W-1:0]  i_addr,
  output logic [CHUNK_N-1:0] _o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_ovf,
  output logic              s
);

  localparam int unsigned PAD_W = NCHUNK * CHUNK_N;
  localparam logic [DATA_N-1:0] NOP_BYTE = DATA_N'(NOP_WORD >> 24);

  logic e_s1_q, e_s_q, g_s1_q, g_s_q;
  logic acc_q;
  logic [DATA_N-1:0] x_data_q, x_data_d;
  logic oe_q, oe_d;
  logic [CHUNK_N-1:0] o_data_q, o_data_d;
  logic s_q, s_d, ovf_q, ovf_d;
  logic [DATA_N-1:0] pat_q [PAT_DEPTH];

  logic acc, acc_nxt, start;
  logic fifo_empty, fifo_full, pop_eff, push_req, push_ok;
  logic [ADDR_N-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [PAD_W-1:0]  head_pad;

  // Strobe synchronisers come out of reset as "inactive" (high)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_s1_q <= 1'b1;
      e_s_q  <= 1'b1;
      g_s1_q <= 1'b1;
      g_s_q  <= 1'b1;
      acc_q  <= 1'b0;
    end else begin
      e_s1_q <= _e;
      e_s_q  <= e_s1_q;
      g_s1_q <= _g;
      g_s_q  <= g_s1_q;
      acc_q  <= acc;
    end
  end

  always_comb begin
    acc        = ~e_s_q & ~g_s_q;
    acc_nxt    = ~e_s1_q & ~g_s1_q;
    start      = acc & ~acc_q;
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == CNT_W'(CAP_DEPTH));
    pop_eff    = i_pop & ~fifo_empty;
    push_req   = start & (i_mode | ~s_q);
    push_ok    = push_req & (~fifo_full | pop_eff);

    x_data_d = x_data_q;
    if (start) x_data_d = pat_q[address[IDX_W-1:0]];
    // Looking one synchroniser stage ahead lets the pad release on the same edge acc falls
    oe_d  = acc & acc_nxt;
    s_d   = i_clr ? 1'b0 : (s_q | push_ok);
    ovf_d = i_clr ? 1'b0 : (ovf_q | (push_req & ~push_ok));

    head_pad = PAD_W'(fifo_head);
    o_data_d = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (i_addr == SEL_W'(k)) o_data_d = head_pad[k*CHUNK_N +: CHUNK_N];
    end
    if (fifo_empty) o_data_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_data_q <= '0;
      oe_q     <= 1'b0;
      o_data_q <= '0;
      s_q      <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      x_data_q <= x_data_d;
      oe_q     <= oe_d;
      o_data_q <= o_data_d;
      s_q      <= s_d;
      ovf_q    <= ovf_d;
    end
  end

  // Pattern RAM: index 0 holds the NOP opcode byte, the rest are zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < PAT_DEPTH; i++) pat_q[i] <= (i == 0) ? NOP_BYTE : '0;
    end else if (i_pat_we) begin
      pat_q[i_pat_idx] <= i_pat_data;
    end
  end

  cap_fifo #(
    .WIDTH (ADDR_N),
    .DEPTH (CAP_DEPTH)
  ) u_cap_fifo (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .push_i   (push_ok),
    .pop_i    (pop_eff),
    .clr_i    (i_clr),
    .data_i   (address),
    .head_c_o (fifo_head),
    .count_o  (fifo_count)
  );

  assign x_data    = x_data_q;
  assign x_data_oe = oe_q;
  assign _o_data   = o_data_q;
  assign o_count   = fifo_count;
  assign o_ovf     = ovf_q;
  assign s         = s_q;

endmodule

// File: tb/tb_boot_flash_emu.sv
// Randomised and directed bench for boot_flash_emu against a queue-based reference model.
module tb_boot_flash_emu;

  localparam int unsigned ADDR_N = 19, DATA_N = 8, PAT_DEPTH = 8, CAP_DEPTH = 4;
  localparam int unsigned CHUNK_N = 2, NCHUNK = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_N-1:0] address;
  logic              e_n, g_n;
  logic [DATA_N-1:0] x_data;
  logic              x_data_oe;
  logic              mode, clr, pat_we, pop;
  logic [2:0]        pat_idx;
  logic [DATA_N-1:0] pat_data;
  logic [3:0]        sel;
  logic [1:0]        o_data;
  logic [2:0]        o_count;
  logic              o_ovf, s_flag;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit                m_e1, m_es, m_g1, m_gs, m_acc_prev;
  logic [DATA_N-1:0] m_pat [PAT_DEPTH];
  logic [ADDR_N-1:0] m_q [$];
  bit                m_s, m_ovf, m_oe;
  logic [DATA_N-1:0] m_xd;
  logic [1:0]        m_od;

  always #5 clk = ~clk;

  boot_flash_emu dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .address    (address),
    ._e         (e_n),
    ._g         (g_n),
    .x_data     (x_data),
    .x_data_oe  (x_data_oe),
    .i_mode     (mode),
    .i_clr      (clr),
    .i_pat_we   (pat_we),
    .i_pat_idx  (pat_idx),
    .i_pat_data (pat_data),
    .i_pop      (pop),
    .i_addr     (sel),
    ._o_data    (o_data),
    .o_count    (o_count),
    .o_ovf      (o_ovf),
    .s          (s_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e1 = 1; m_es = 1; m_g1 = 1; m_gs = 1; m_acc_prev = 0;
    for (int i = 0; i < PAT_DEPTH; i++) m_pat[i] = '0;
    m_pat[0] = 8'h60;
    m_q.delete();
    m_s = 0; m_ovf = 0; m_oe = 0; m_xd = '0; m_od = '0;
  endtask

  // One rising edge of the behavioural model, using the inputs held before the edge
  task automatic model_edge();
    bit acc, acc_nx, start, pop_eff;
    int occ;
    logic [31:0] h;
    acc    = !m_es && !m_gs;
    acc_nx = !m_e1 && !m_g1;
    start  = acc && !m_acc_prev;
    if (m_q.size() == 0 || sel >= NCHUNK) m_od = '0;
    else begin
      h    = 32'(m_q[0]);
      m_od = 2'(h >> (CHUNK_N * sel));
    end
    if (start) m_xd = m_pat[address % PAT_DEPTH];
    m_oe = acc && acc_nx;
    if (clr) begin
      m_q.delete(); m_s = 0; m_ovf = 0;
    end else begin
      occ     = m_q.size();
      pop_eff = pop && occ > 0;
      if (pop_eff) void'(m_q.pop_front());
      if (start && (mode || !m_s)) begin
        if (occ < CAP_DEPTH || pop_eff) begin
          m_q.push_back(address);
          m_s = 1;
        end else m_ovf = 1;
      end
    end
    if (pat_we) m_pat[pat_idx] = pat_data;
    m_acc_prev = acc;
    m_es = m_e1; m_e1 = e_n;
    m_gs = m_g1; m_g1 = g_n;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("x_data", x_data, m_xd);
    chk("x_data_oe", x_data_oe, m_oe);
    chk("o_data", o_data, m_od);
    chk("o_count", o_count, m_q.size());
    chk("o_ovf", o_ovf, m_ovf);
    chk("s", s_flag, m_s);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_x_data", x_data, 0);
    chk("rst_oe", x_data_oe, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_s", s_flag, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fetch(input logic [ADDR_N-1:0] a);
    address = a; e_n = 0; g_n = 0;
    repeat (4) cyc();
    chk("oe_active", x_data_oe, 1);
    e_n = 1; g_n = 1;
    repeat (4) cyc();
  endtask

  task automatic pulse_clr();
    clr = 1; cyc(); clr = 0;
  endtask

  initial begin
    rst_n = 1; address = '0; e_n = 1; g_n = 1; mode = 0; clr = 0;
    pat_we = 0; pat_idx = '0; pat_data = '0; pop = 0; sel = '0;
    model_reset();
    #2;
    do_reset();

    // First fetch and full slice readout, including out-of-range selects
    fetch(19'h4ABCD);
    chk("t1_x_data", x_data, 8'h00);
    chk("t1_s", s_flag, 1);
    chk("t1_count", o_count, 1);
    for (int k = 0; k < 16; k++) begin
      sel = 4'(k);
      cyc();
    end

    // Mode 0: only the first fetch after a clear is kept
    pulse_clr();
    fetch(19'h00000); chk("m0_xd0", x_data, 8'h60);
    fetch(19'h00001); chk("m0_xd1", x_data, 8'h00);
    fetch(19'h00002); chk("m0_xd2", x_data, 8'h00);
    chk("m0_count", o_count, 1);

    // Mode 1 overflow then drain, with one extra pop on empty
    pulse_clr();
    mode = 1;
    for (int k = 0; k < 5; k++) fetch(19'($urandom));
    chk("m1_count", o_count, 4);
    chk("m1_ovf", o_ovf, 1);
    for (int k = 0; k < 5; k++) begin
      sel = 4'($urandom_range(0, 9));
      pop = 1; cyc(); pop = 0; cyc();
    end
    chk("m1_drained", o_count, 0);

    // Simultaneous push and pop while full
    pulse_clr();
    for (int k = 0; k < 4; k++) fetch(19'($urandom));
    address = 19'h5A5A5; e_n = 0; g_n = 0;
    cyc(); cyc();
    pop = 1; cyc(); pop = 0;
    cyc();
    e_n = 1; g_n = 1;
    repeat (4) cyc();
    chk("pp_count", o_count, 4);
    chk("pp_ovf", o_ovf, 0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < NCHUNK; j++) begin
        sel = 4'(j); cyc();
      end
      pop = 1; cyc(); pop = 0;
    end

    // Pattern write during an active access only affects later fetches
    mode = 0;
    pulse_clr();
    address = '0; e_n = 0; g_n = 0;
    repeat (4) cyc();
    pat_we = 1; pat_idx = 3'd0; pat_data = 8'h48;
    cyc();
    pat_we = 0;
    cyc();
    chk("pw_hold", x_data, 8'h60);
    e_n = 1; g_n = 1;
    repeat (4) cyc();
    fetch(19'h00008);
    chk("pw_new", x_data, 8'h48);

    // Reset in the middle of an access restores the NOP pattern
    address = '0; e_n = 0; g_n = 0;
    repeat (3) cyc();
    do_reset();
    repeat (5) cyc();
    e_n = 1; g_n = 1;
    repeat (4) cyc();
    chk("rst_pat", x_data, 8'h60);

    // Reset in the middle of readout, then clear keeps the pattern
    pat_we = 1; pat_idx = 3'd1; pat_data = 8'h7F; cyc(); pat_we = 0;
    fetch(19'h12345);
    sel = 4'd2; cyc();
    do_reset();
    pat_we = 1; pat_idx = 3'd1; pat_data = 8'h7F; cyc(); pat_we = 0;
    fetch(19'h00010);
    chk("clr_pre_s", s_flag, 1);
    pulse_clr();
    chk("clr_count", o_count, 0);
    chk("clr_s", s_flag, 0);
    fetch(19'h00001);
    chk("clr_pat_kept", x_data, 8'h7F);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) e_n = ~e_n;
      if ($urandom_range(0, 7) == 0) g_n = ~g_n;
      if (e_n) address = 19'($urandom);
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      pop      = ($urandom_range(0, 9) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      pat_we   = ($urandom_range(0, 15) == 0);
      pat_idx  = 3'($urandom);
      pat_data = 8'($urandom);
      sel      = 4'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
